obi_sram_secondary: RTL and testbench

- OBI secondary (responder) that terminates an OBI bus and drives a single-port synchronous SRAM macro port (csb/web/wmask/addr/din/dout).
- Sits on the peripheral side of the OBI CDC bridges, or directly on a core bus, in front of an on-chip SRAM.
- Supports pipelined back-to-back requests, fixed in-order response latency, an address-range error response and an external arbitration stall.

---
 rtl/obi_pkg.sv | 21 ++
 rtl/obi_sram_secondary_if.sv | 30 +++
 rtl/obi_rsp_pipe.sv | 41 ++++
 rtl/obi_sram_secondary.sv | 106 ++++++++++
 tb/tb_obi_sram_secondary.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/obi_pkg.sv
// ---------------------------------------------------------------------------
// obi_pkg
// Shared definitions for the OBI SRAM secondary and its response pipeline.
//   RD_LAT_MIN/RD_LAT_MAX : legal range of SRAM read latency
//   OBI_ERR_RDATA         : read data returned with an error response
//   obi_rsp_meta_t        : per-request response bookkeeping {valid, err, we}
// ---------------------------------------------------------------------------
package obi_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  localparam logic [31:0] OBI_ERR_RDATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic valid;
    logic err;
    logic we;
  } obi_rsp_meta_t;

endpackage

// File: rtl/obi_sram_secondary_if.sv
// ---------------------------------------------------------------------------
// obi_sram_secondary_if
// OBI request/response channel between a manager and the SRAM secondary.
//   req, addr, we, be, wdata : request side, driven by the manager
//   gnt                      : request accepted, driven by the secondary
//   rvalid, rdata, err       : response side, driven by the secondary
// ---------------------------------------------------------------------------
interface obi_sram_secondary_if;

  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/obi_rsp_pipe.sv
// ---------------------------------------------------------------------------
// obi_rsp_pipe
// Fixed-depth shift register carrying response metadata from the grant cycle
// to the response cycle. Every stage shifts every cycle, so it never stalls
// or overflows.
//   clk_i  : clock
//   rst_i  : synchronous active-high clear of every stage
//   i_meta : metadata of the request granted this cycle
//   o_meta : metadata of the request whose response is due this cycle
// ---------------------------------------------------------------------------
module obi_rsp_pipe
  import obi_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  obi_rsp_meta_t i_meta,
  output obi_rsp_meta_t o_meta
);

  obi_rsp_meta_t r_stage [DEPTH];

  // Shift one stage per cycle; a reset drops everything in flight so no
  // response is ever issued for a request accepted before the reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_meta;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_meta = r_stage[DEPTH-1];

endmodule

// File: rtl/obi_sram_secondary.sv
// ---------------------------------------------------------------------------
// obi_sram_secondary
// OBI secondary that terminates an OBI bus and drives a single-port
// synchronous SRAM macro. Accepts one request per cycle, answers in order
// exactly RD_LAT cycles after the grant, and flags accesses outside the
// SRAM window with an error response that leaves the SRAM untouched.
//   clk_i        : clock for bus and SRAM
//   rst_i        : synchronous active-high reset
//   obi          : OBI channel (slave modport)
//   arb_stall_i  : SRAM port owned by another master, blocks grant
//   sram_csb_o   : chip select, active-low
//   sram_web_o   : write enable, active-low
//   sram_wmask_o : byte write mask
//   sram_addr_o  : word address
//   sram_din_o   : write data
//   sram_dout_i  : read data, valid RD_LAT cycles after the access edge
// ---------------------------------------------------------------------------
module obi_sram_secondary
  import obi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
  parameter int          ADDR_WORDS = 256,
  parameter int          AW         = $clog2(ADDR_WORDS),
  parameter int          RD_LAT     = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  obi_sram_secondary_if.slave     obi,
  input  logic                    arb_stall_i,
  output logic                    sram_csb_o,
  output logic                    sram_web_o,
  output logic [3:0]              sram_wmask_o,
  output logic [AW-1:0]           sram_addr_o,
  output logic [31:0]             sram_din_o,
  input  logic [31:0]             sram_dout_i
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_badLat
    $error("obi_sram_secondary: RD_LAT must be 1 or 2");
  end

  localparam logic [31:0] WindowBytes = 32'(ADDR_WORDS * 4);

  logic [31:0]   w_offset;
  logic          w_inRange;
  logic          w_gnt;
  logic          w_access;
  obi_rsp_meta_t w_reqMeta;
  obi_rsp_meta_t w_rspMeta;

  // A single unsigned subtract covers both ends of the window: addresses
  // below the base wrap to huge offsets and fail the compare.
  assign w_offset  = obi.addr - ADDR_BASE;
  assign w_inRange = (w_offset < WindowBytes);

  assign w_gnt    = obi.req && !arb_stall_i && !rst_i;
  assign w_access = w_gnt && w_inRange;
  assign obi.gnt  = w_gnt;

  // SRAM macro drive straight from the granted request; idle values keep
  // address and data at zero so the macro pins don't toggle needlessly.
  always_comb begin
    sram_csb_o   = 1'b1;
    sram_web_o   = 1'b1;
    sram_wmask_o = '0;
    sram_addr_o  = '0;
    sram_din_o   = '0;
    if (w_access) begin
      sram_csb_o   = 1'b0;
      sram_web_o   = !obi.we;
      sram_wmask_o = obi.we ? obi.be : 4'b0000;
      sram_addr_o  = w_offset[AW+1:2];
      sram_din_o   = obi.wdata;
    end
  end

  // Out-of-range requests are still granted and tracked so the response
  // order and latency look identical to an in-range access.
  assign w_reqMeta = '{valid: w_gnt, err: w_gnt && !w_inRange, we: obi.we};

  obi_rsp_pipe #(
    .DEPTH (RD_LAT)
  ) u_rspPipe (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_meta (w_reqMeta),
    .o_meta (w_rspMeta)
  );

  // Response formatting: read data only for in-range reads, a fixed error
  // pattern for out-of-range accesses, and all-zero when nothing is valid.
  always_comb begin
    obi.rvalid = w_rspMeta.valid;
    obi.err    = 1'b0;
    obi.rdata  = '0;
    if (w_rspMeta.valid) begin
      if (w_rspMeta.err) begin
        obi.err   = 1'b1;
        obi.rdata = OBI_ERR_RDATA;
      end else if (!w_rspMeta.we) begin
        obi.rdata = sram_dout_i;
      end
    end
  end

endmodule

// File: tb/tb_obi_sram_secondary.sv
// ---------------------------------------------------------------------------
// tb_obi_sram_secondary
// Drives two copies of the secondary (RD_LAT = 1 and RD_LAT = 2) with the
// same request stream, each in front of its own behavioural SRAM macro, and
// compares every cycle against a word-array / response-queue model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_obi_sram_secondary;
  import obi_pkg::*;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          WORDS = 256;
  localparam int          AWB   = 8;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        stall;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  int          cycle = 0;
  bit          primed = 1'b0;
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  // Cycle counter and the point from which registered outputs are defined
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (rst) primed <= 1'b1;
  end

  function automatic logic [31:0] initWord(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h0F1E_2D3C;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s @cycle %0d: got %h, expected %h", name, cycle, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = g + 1;

    obi_sram_secondary_if bus ();
    logic           csb;
    logic           web;
    logic [3:0]     wmask;
    logic [AWB-1:0] saddr;
    logic [31:0]    din;
    logic [31:0]    dout;
    logic [31:0]    sramMem  [WORDS];
    logic [31:0]    doutPipe [LAT];
    logic [31:0]    modelMem [WORDS];
    rsp_t           expQ [$];
    int             rspCount = 0;

    assign bus.req   = req;
    assign bus.addr  = addr;
    assign bus.we    = we;
    assign bus.be    = be;
    assign bus.wdata = wdata;

    obi_sram_secondary #(
      .ADDR_BASE  (BASE),
      .ADDR_WORDS (WORDS),
      .RD_LAT     (LAT)
    ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .obi          (bus),
      .arb_stall_i  (stall),
      .sram_csb_o   (csb),
      .sram_web_o   (web),
      .sram_wmask_o (wmask),
      .sram_addr_o  (saddr),
      .sram_din_o   (din),
      .sram_dout_i  (dout)
    );

    initial begin
      for (int i = 0; i < WORDS; i++) begin
        sramMem[i]  = initWord(i);
        modelMem[i] = initWord(i);
      end
    end

    // Behavioural SRAM macro: masked write or read capture at the access
    // edge, read data delayed through LAT register stages.
    always @(posedge clk) begin : macro
      logic [31:0] word;
      if (!csb) begin
        if (!web) begin
          word = sramMem[saddr];
          for (int b = 0; b < 4; b++) if (wmask[b]) word[8*b +: 8] = din[8*b +: 8];
          sramMem[saddr] <= word;
        end else begin
          doutPipe[0] <= sramMem[saddr];
        end
      end
      for (int i = 1; i < LAT; i++) doutPipe[i] <= doutPipe[i-1];
    end
    assign dout = doutPipe[LAT-1];

    // Reference model and compare, once per cycle mid-period
    always @(negedge clk) begin : cmp
      logic        expGnt;
      logic        hit;
      logic        access;
      logic        expValid;
      int          idx;
      longint      a;
      rsp_t        r;
      logic [31:0] word;
      a      = longint'(addr);
      hit    = (a >= longint'(BASE)) && (a < longint'(BASE) + WORDS * 4);
      idx    = hit ? int'((a - longint'(BASE)) / 4) : 0;
      expGnt = req && !stall && !rst;
      access = expGnt && hit;

      checkOutput($sformatf("L%0d gnt", LAT), 32'(bus.gnt), 32'(expGnt));
      checkOutput($sformatf("L%0d csb", LAT), 32'(csb), 32'(!access));
      if (access) begin
        checkOutput($sformatf("L%0d web", LAT), 32'(web), 32'(!we));
        checkOutput($sformatf("L%0d wmask", LAT), 32'(wmask), we ? 32'(be) : 32'd0);
        checkOutput($sformatf("L%0d addr", LAT), 32'(saddr), 32'(idx));
        checkOutput($sformatf("L%0d din", LAT), din, wdata);
      end else begin
        checkOutput($sformatf("L%0d idle web", LAT), 32'(web), 32'd1);
        checkOutput($sformatf("L%0d idle wmask", LAT), 32'(wmask), 32'd0);
      end

      if (primed) begin
        expValid = (expQ.size() > 0) && (expQ[0].due == cycle);
        checkOutput($sformatf("L%0d rvalid", LAT), 32'(bus.rvalid), 32'(expValid));
        if (expValid) begin
          r = expQ.pop_front();
          checkOutput($sformatf("L%0d err", LAT), 32'(bus.err), 32'(r.err));
          checkOutput($sformatf("L%0d rdata", LAT), bus.rdata, r.rdata);
          rspCount++;
        end else begin
          checkOutput($sformatf("L%0d idle err", LAT), 32'(bus.err), 32'd0);
          checkOutput($sformatf("L%0d idle rdata", LAT), bus.rdata, 32'd0);
        end
      end

      if (rst) begin
        expQ.delete();
      end else if (expGnt) begin
        r.due = cycle + LAT;
        r.err = !hit;
        if (!hit) r.rdata = 32'hDEAD_BEEF;
        else if (we) r.rdata = 32'd0;
        else r.rdata = modelMem[idx];
        expQ.push_back(r);
        if (hit && we) begin
          word = modelMem[idx];
          for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
          modelMem[idx] = word;
        end
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic s, input logic q, input logic w,
                               input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst = r; stall = s; req = q; we = w; addr = a; be = b; wdata = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 32'd0, 4'd0, 32'd0);
  endtask

  task automatic waitSample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int base1;
    rst = 1; stall = 0; req = 1; we = 0; addr = BASE; be = 4'hF; wdata = 0;

    // Reset held three cycles with a request pending
    applyStimulus(1, 0, 1, 0, BASE, 4'hF, 0);
    applyStimulus(1, 0, 1, 0, BASE, 4'hF, 0);
    waitSample();
    checkOutput("reset gnt", 32'(lane[0].bus.gnt), 32'd0);
    checkOutput("reset csb", 32'(lane[0].csb), 32'd1);
    applyStimulus(0, 0, 1, 0, BASE, 4'hF, 0);
    waitSample();
    checkOutput("first gnt", 32'(lane[0].bus.gnt), 32'd1);

    // Full write then read back
    applyStimulus(0, 0, 1, 1, 32'h3000_0010, 4'hF, 32'hA5A5_1234);
    waitSample();
    checkOutput("wr wmask", 32'(lane[0].wmask), 32'hF);
    checkOutput("wr addr", 32'(lane[0].saddr), 32'd4);
    applyStimulus(0, 0, 1, 0, 32'h3000_0010, 4'hF, 0);
    idle(1);
    waitSample();
    checkOutput("rd rvalid", 32'(lane[0].bus.rvalid), 32'd1);
    checkOutput("rd rdata", lane[0].bus.rdata, 32'hA5A5_1234);
    checkOutput("model word4", lane[0].modelMem[4], 32'hA5A5_1234);

    // Partial write into a known word
    applyStimulus(0, 0, 1, 1, 32'h3000_0020, 4'hF, 32'h1122_3344);
    applyStimulus(0, 0, 1, 1, 32'h3000_0020, 4'b0010, 32'h0000_CC00);
    applyStimulus(0, 0, 1, 0, 32'h3000_0020, 4'hF, 0);
    idle(1);
    waitSample();
    checkOutput("partial rdata", lane[0].bus.rdata, 32'h1122_CC44);
    checkOutput("model word8", lane[1].modelMem[8], 32'h1122_CC44);

    // Four back-to-back reads
    idle(2);
    base1 = lane[1].rspCount;
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, BASE + 32'(4 * i), 4'hF, 0);
    idle(2);
    waitSample();
    checkOutput("b2b count", 32'(lane[1].rspCount - base1), 32'd4);

    // Out-of-range read below and write above the window
    applyStimulus(0, 0, 1, 0, 32'h2FFF_FFFC, 4'hF, 0);
    applyStimulus(0, 0, 1, 1, 32'h3000_0400, 4'hF, 32'h1234_5678);
    waitSample();
    checkOutput("oor csb", 32'(lane[0].csb), 32'd1);
    checkOutput("oor err", 32'(lane[0].bus.err), 32'd1);
    checkOutput("oor rdata", lane[0].bus.rdata, 32'hDEAD_BEEF);
    idle(2);

    // Arbitration stall with a held request
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0, 32'h3000_0010, 4'hF, 0);
    applyStimulus(0, 0, 1, 0, 32'h3000_0010, 4'hF, 0);
    waitSample();
    checkOutput("stall release gnt", 32'(lane[0].bus.gnt), 32'd1);

    // Write with no byte enables leaves the word alone
    applyStimulus(0, 0, 1, 1, 32'h3000_0010, 4'h0, 32'hFFFF_FFFF);
    applyStimulus(0, 0, 1, 0, 32'h3000_0010, 4'hF, 0);
    idle(1);
    waitSample();
    checkOutput("be0 rdata", lane[0].bus.rdata, 32'hA5A5_1234);

    // Reset one cycle after a grant drops the RD_LAT=2 response
    idle(2);
    base1 = lane[1].rspCount;
    applyStimulus(0, 0, 1, 0, BASE, 4'hF, 0);
    applyStimulus(1, 0, 0, 0, 32'd0, 4'd0, 0);
    idle(3);
    waitSample();
    checkOutput("reset drop", 32'(lane[1].rspCount - base1), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic        nr, ns, nq, nw;
      logic [31:0] na, nd;
      logic [3:0]  nb;
      nr = ($urandom_range(0, 99) < 2);
      ns = ($urandom_range(0, 99) < 20);
      if (req && stall && !rst && !nr) begin
        applyStimulus(nr, ns, 1, we, addr, be, wdata);
      end else begin
        nq = ($urandom_range(0, 99) < 80);
        nw = $urandom_range(0, 1) == 1;
        nb = 4'($urandom_range(0, 15));
        nd = $urandom;
        case ($urandom_range(0, 19))
          0:       na = BASE - 32'd4;
          1:       na = BASE + 32'd1024;
          2:       na = $urandom;
          default: na = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        endcase
        applyStimulus(nr, ns, nq, nw, na, nb, nd);
      end
    end
    idle(4);
    waitSample();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
